// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state encoding and width helpers for the Sobel edge stream
package edge_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } edge_state_t;

  localparam int DEF_PIX_W = 8;

  // Signed gradient width: |G| <= 4*(2^PIX_W-1) plus a sign bit
  function automatic int grad_width(input int pix_w);
    return pix_w + 4;
  endfunction

  // Unsigned magnitude width: |Gx|+|Gy| <= 8*(2^PIX_W-1)
  function automatic int mag_width(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/edge_line_buf.sv
// rtl/edge_line_buf.sv - DEPTH-deep pixel delay line advanced by an enable
module edge_line_buf import edge_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // The slot about to be overwritten holds the sample pushed DEPTH pushes ago
  assign dout = mem[ptr];

  // Circular write pointer; its phase is irrelevant, only the DEPTH-push distance matters
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
    end
  end

  // Storage needs no reset: stale contents only ever reach border positions
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/edge_sobel_stream.sv
// rtl/edge_sobel_stream.sv - streaming 3x3 Sobel edge detector; EDGE_MAG_OUT_EN selects saturated magnitude output
module edge_sobel_stream import edge_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W+2:0] T,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  output logic             in_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pix,
  input  logic             out_ready,
  output logic             busy,
  output logic             ready_out
);

  localparam int GRAD_W = grad_width(PIX_W);
  localparam int MAG_W  = mag_width(PIX_W);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int FW     = $clog2(IMG_W + 2);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FILL_FULL  = FW'(IMG_W + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

  edge_state_t state, state_nx;

  logic             adv;
  logic             accept;
  logic             inject;
  logic             shift;
  logic             frame_start;
  logic             fill_full;
  logic             last_pix;
  logic             flush_last;
  logic             drain_done;

  logic [MAG_W-1:0] t_q;
  logic [RW-1:0]    in_row, c_row;
  logic [CW-1:0]    in_col, c_col;
  logic [FW-1:0]    fill_cnt, flush_cnt;

  logic [PIX_W-1:0] sample, lb0_out, lb1_out;
  logic [PIX_W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

  logic             v0, border0;
  logic             v1, border1;
  logic signed [GRAD_W-1:0] gx, gy, gx_q, gy_q;
  logic [GRAD_W-1:0] abs_gx, abs_gy, mag;
  logic [PIX_W-1:0]  res_pix;

  // Whole pipeline moves together whenever the output register can take a new value
  assign adv         = !out_valid || out_ready;
  assign shift       = accept || inject;
  assign frame_start = (state == IDLE) && start;
  assign fill_full   = (fill_cnt == FILL_FULL);
  assign last_pix    = (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign flush_last  = (flush_cnt == FLUSH_LAST);
  // Last result is the only valid item left once stages 0 and 1 are empty in DRAIN
  assign drain_done  = out_valid && out_ready && !v1 && !v0;
  assign sample      = inject ? '0 : in_pix;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    ready_out = 1'b0;
    accept    = 1'b0;
    inject    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = RUN;
      end
      RUN: begin
        in_ready = adv;
        accept   = adv && in_valid;
        if (accept && last_pix) state_nx = FLUSH;
      end
      FLUSH: begin
        inject = adv;
        if (adv && flush_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_nx = DONE;
      end
      DONE: begin
        ready_out = 1'b1;
        state_nx  = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Threshold is frozen for the whole frame at start
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q <= '0;
    end else if (frame_start) begin
      t_q <= T;
    end
  end

  // Input raster position, window fill level, centre position and flush count
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      in_row    <= '0;
      in_col    <= '0;
      c_row     <= '0;
      c_col     <= '0;
      fill_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept) begin
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (inject) begin
        flush_cnt <= flush_cnt + FW'(1);
      end
      if (shift) begin
        if (fill_full) begin
          if (c_col == COL_LAST) begin
            c_col <= '0;
            c_row <= c_row + RW'(1);
          end else begin
            c_col <= c_col + CW'(1);
          end
        end else begin
          fill_cnt <= fill_cnt + FW'(1);
        end
      end
    end
  end

  edge_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
    .clk   (clk),
    .reset (reset),
    .en    (shift),
    .din   (sample),
    .dout  (lb0_out)
  );

  edge_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
    .clk   (clk),
    .reset (reset),
    .en    (shift),
    .din   (lb0_out),
    .dout  (lb1_out)
  );

  // 3x3 window: newest sample enters bottom-right, older rows come from the line buffers
  always_ff @(posedge clk) begin
    if (shift) begin
      p00 <= p01;  p01 <= p02;  p02 <= lb1_out;
      p10 <= p11;  p11 <= p12;  p12 <= lb0_out;
      p20 <= p21;  p21 <= p22;  p22 <= sample;
    end
  end

  // Stage 0 valid: window centre is a real position once IMG_W+1 samples have entered
  always_ff @(posedge clk) begin
    if (reset) begin
      v0      <= 1'b0;
      border0 <= 1'b0;
    end else if (adv) begin
      v0 <= shift && fill_full;
      if (shift && fill_full) begin
        border0 <= (c_row == '0) || (c_row == ROW_LAST) ||
                   (c_col == '0) || (c_col == COL_LAST);
      end
    end
  end

  function automatic logic signed [GRAD_W-1:0] wid(input logic [PIX_W-1:0] p);
    return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
  endfunction

  // Sobel kernels over the current window
  always_comb begin
    gx = (wid(p02) + wid(p12) + wid(p12) + wid(p22)) -
         (wid(p00) + wid(p10) + wid(p10) + wid(p20));
    gy = (wid(p20) + wid(p21) + wid(p21) + wid(p22)) -
         (wid(p00) + wid(p01) + wid(p01) + wid(p02));
  end

  // Stage 1: registered gradients
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      border1 <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
    end else if (adv) begin
      v1      <= v0;
      border1 <= border0;
      gx_q    <= gx;
      gy_q    <= gy;
    end
  end

  // Magnitude and output decision; magnitude kept at gradient width so compares see every bit
`ifdef EDGE_MAG_OUT_EN
  localparam logic [GRAD_W-1:0] PIX_MAX = GRAD_W'((1 << PIX_W) - 1);
`endif
  always_comb begin
    abs_gx  = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_gy  = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag     = abs_gx + abs_gy;
`ifdef EDGE_MAG_OUT_EN
    res_pix = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
`else
    res_pix = (mag > {{(GRAD_W-MAG_W){1'b0}}, t_q}) ? '1 : '0;
`endif
    if (border1) begin
      res_pix = '0;
    end
  end

  // Stage 2: output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
    end else if (adv) begin
      out_valid <= v1;
      out_pix   <= v1 ? res_pix : '0;
    end
  end

endmodule

// File: tb/tb_edge_sobel_stream.sv
// tb/tb_edge_sobel_stream.sv - directed self-checking bench for edge_sobel_stream
module tb_edge_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int NPIX  = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PIX_W+2:0] T;
  logic             in_valid;
  logic [PIX_W-1:0] in_pix;
  logic             in_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic             out_ready;
  logic             busy;
  logic             ready_out;

  edge_sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .T         (T),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pix   (out_pix),
    .out_ready (out_ready),
    .busy      (busy),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PIX_W-1:0] got [NPIX];
  int   ocount;
  int   pulses;
  int   stall_bad;
  int   first_out;
  int   cycles;
  bit   timed_out;
  logic busy_end;

  // mode 0: flat 100; mode 1: left half 0, right half hi
  function automatic logic [PIX_W-1:0] src_pix(input int mode, input int hi, input int idx);
    int c;
    c = idx % IMG_W;
    if (mode == 0) return 8'd100;
    return (c >= 32) ? 8'(hi) : 8'd0;
  endfunction

  // Vertical step with mag above threshold: edges at cols 31/32 on interior rows
  function automatic logic [PIX_W-1:0] exp_step(input int idx);
    int r, c;
    r = idx / IMG_W;
    c = idx % IMG_W;
    return (r >= 1 && r <= IMG_H - 2 && (c == 31 || c == 32)) ? 8'hFF : 8'h00;
  endfunction

  task automatic start_frame(input logic [PIX_W+2:0] thr);
    @(negedge clk);
    T     = thr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one frame and records every output handshake
  task automatic run_frame(input int mode, input int hi, input bit rnd_ready,
                           input int abort_at, input int poke_at);
    int sent;
    int post;
    sent = 0; post = 0;
    ocount = 0; pulses = 0; stall_bad = 0; first_out = -1; cycles = 0; timed_out = 0;
    while (1) begin
      @(negedge clk);
      if (abort_at >= 0 && sent == abort_at) break;
      if (pulses > 0) begin
        if (post >= 4) break;
        post++;
      end
      if (cycles >= 30000) begin
        timed_out = 1;
        break;
      end
      if (poke_at >= 0) begin
        start = (sent == poke_at);
        if (sent >= poke_at) T = '0;
      end
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < NPIX);
      in_pix    = (sent < NPIX) ? src_pix(mode, hi, sent) : 8'h00;
      #1;
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cycles;
        if (ocount < NPIX) got[ocount] = out_pix;
        ocount++;
      end
      if (out_valid && !out_ready && in_ready) stall_bad++;
      if (in_valid && in_ready) sent++;
      if (ready_out) pulses++;
      busy_end = busy;
      cycles++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; T = '0; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_pix !== 8'h00)  begin n_fail++; $display("FAIL reset_out_pix: got %0d expected 0", out_pix); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready_out: got %b expected 0", ready_out); end
    reset = 1'b0;
  endtask

  task automatic test_flat;
    int bad, first_bad;
    start_frame(11'd10);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flat_busy_run: got %b expected 1", busy); end
    run_frame(0, 100, 1'b0, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== 8'h00) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL flat_timeout: got %b expected 0", timed_out); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL flat_pixels: %0d wrong, first idx %0d got %0d expected 0", bad, first_bad, got[first_bad]); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL flat_count: got %0d expected %0d", ocount, NPIX); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL flat_ready_out: got %0d pulses expected 1", pulses); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL flat_busy_after: got %b expected 0", busy_end); end
    n_checks++; if (first_out !== 68) begin n_fail++; $display("FAIL flat_latency: first output cycle %0d expected 68", first_out); end
  endtask

  task automatic test_step;
    int bad, first_bad;
    start_frame(11'd63);
    run_frame(1, 200, 1'b0, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== exp_step(i)) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL step_pixels: %0d wrong, first idx %0d got %0d expected %0d", bad, first_bad, got[first_bad], exp_step(first_bad)); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL step_count: got %0d expected %0d", ocount, NPIX); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL step_ready_out: got %0d pulses expected 1", pulses); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL step_busy_after: got %b expected 0", busy_end); end
  endtask

  task automatic test_threshold_boundary;
    int bad, first_bad;
    start_frame(11'd64);
    run_frame(1, 16, 1'b0, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== 8'h00) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL thr_equal_pixels: %0d wrong, first idx %0d got %0d expected 0", bad, first_bad, got[first_bad]); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL thr_equal_count: got %0d expected %0d", ocount, NPIX); end
    start_frame(11'd63);
    run_frame(1, 16, 1'b0, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== exp_step(i)) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL thr_below_pixels: %0d wrong, first idx %0d got %0d expected %0d", bad, first_bad, got[first_bad], exp_step(first_bad)); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL thr_below_ready_out: got %0d pulses expected 1", pulses); end
  endtask

  task automatic test_backpressure;
    int bad, first_bad;
    start_frame(11'd63);
    run_frame(1, 200, 1'b1, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== exp_step(i)) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", timed_out); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_pixels: %0d wrong, first idx %0d got %0d expected %0d", bad, first_bad, got[first_bad], exp_step(first_bad)); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", ocount, NPIX); end
    n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_in_ready_stalled: %0d stalled cycles with in_ready high, expected 0", stall_bad); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL bp_ready_out: got %0d pulses expected 1", pulses); end
  endtask

  task automatic test_reset_midframe;
    int bad, first_bad;
    start_frame(11'd63);
    run_frame(1, 200, 1'b0, 1000, -1);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    start_frame(11'd63);
    run_frame(1, 200, 1'b0, -1, -1);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== exp_step(i)) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_pixels: %0d wrong, first idx %0d got %0d expected %0d", bad, first_bad, got[first_bad], exp_step(first_bad)); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL midreset_count: got %0d expected %0d", ocount, NPIX); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL midreset_ready_out: got %0d pulses expected 1", pulses); end
  endtask

  task automatic test_t_change;
    int bad, first_bad;
    start_frame(11'd63);
    run_frame(1, 200, 1'b0, -1, 1000);
    bad = 0; first_bad = -1;
    for (int i = 0; i < NPIX; i++) if (got[i] !== exp_step(i)) begin bad++; if (first_bad < 0) first_bad = i; end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tchange_pixels: %0d wrong, first idx %0d got %0d expected %0d", bad, first_bad, got[first_bad], exp_step(first_bad)); end
    n_checks++; if (ocount !== NPIX) begin n_fail++; $display("FAIL tchange_count: got %0d expected %0d", ocount, NPIX); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL tchange_ready_out: got %0d pulses expected 1", pulses); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL tchange_busy_after: got %b expected 0", busy_end); end
  endtask

  initial begin
    test_reset;
    test_flat;
    test_step;
    test_threshold_boundary;
    test_backpressure;
    test_reset_midframe;
    test_t_change;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_sobel_stream.md
Name: edge_sobel_stream

Overview:
- Parametrised streaming Sobel edge detector for greyscale frames; successor to the fixed-size, threshold-only edge core.
- Accepts one raster-order pixel per valid/ready handshake and keeps two line buffers plus a 3x3 window.
- Emits one result per pixel position with backpressure support, then pulses ready_out at end of frame.
- Sits between the image source (memory reader) and the result writer in the top-level datapath.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 64, frame width in pixels; must be >= 3.
- IMG_H, 64, frame height in pixels; must be >= 3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- T  in  PIX_W+3  edge threshold; latched at start
- in_valid  in  1  input pixel valid
- in_pix  in  PIX_W  input pixel, raster order
- in_ready  out  1  input handshake ready
- out_valid  out  1  result valid
- out_pix  out  PIX_W  result pixel
- out_ready  in  1  downstream ready
- busy  out  1  high in every state except IDLE
- ready_out  out  1  one-cycle end-of-frame pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk and reset port is reset.
- Reset (any state, including mid-frame):
  - Next state IDLE.
  - in_ready, out_valid, out_pix, busy and ready_out are all 0.
  - Counters and stage-valid bits are cleared.
  - Line buffer contents are don't-care, because borders are handled by counters.
- FSM states:
  - IDLE: on start, latch T into T_q, clear row/col counters, go to RUN.
  - RUN: accept exactly IMG_W*IMG_H pixels. On the last accept, go to FLUSH.
  - FLUSH: inject IMG_W+1 internal zero pseudo-pixels, one per pipeline advance. in_ready=0. Then go to DRAIN.
  - DRAIN: wait until the last output handshake completes, then go to DONE.
  - DONE: ready_out=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE. T changes after start have no effect on the current frame.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = (state==RUN) && adv. All stages hold when adv=0.
- Stage 0 (accept edge): shift the window; push into the line buffers.
- Output index k (raster) is centred on the window formed when sample k+IMG_W+1 (real or pseudo) enters.
  - Results start only after IMG_W+1 samples.
  - Stage-valid bits track fill.
- Stage 1: register Gx and Gy, signed, PIX_W+4 bits.
  - Gx = (p02+2p12+p22)-(p00+2p10+p20).
  - Gy = (p20+2p21+p22)-(p00+2p01+p02).
- Stage 2:
  - mag = |Gx|+|Gy|, unsigned, PIX_W+3 bits; never overflows (max 8*(2^PIX_W-1)).
  - edge = mag > T_q (strict).
  - out_pix = edge ? all-ones : 0.
- Latency with out_ready=1: out_valid is high in the cycle 2 edges after the edge that consumes sample k+IMG_W+1.
- Border: positions with row 0, row IMG_H-1, col 0 or col IMG_W-1 output 0 regardless of mag.
- Exactly IMG_W*IMG_H outputs per frame, in raster order, with no drops or duplicates under any out_ready pattern.
- Counters wrap col at IMG_W-1 to 0 and increment row. Raster-end detection uses row==IMG_H-1 && col==IMG_W-1.
- in_valid while in_ready=0 is ignored. A data change while stalled is not sampled.

Optional Feature:
- Macro: EDGE_MAG_OUT_EN.
- Defined: out_pix = saturated mag, i.e. min(mag, 2^PIX_W-1). Border positions are still 0, and T_q is unused for the output.
- Undefined: binary output as above.

Decomposition:
- Package edge_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DRAIN, DONE);
  - the default PIX_W;
  - localparam-style width helpers (GRAD_W = PIX_W+4, MAG_W = PIX_W+3).
- Sub-module edge_line_buf: IMG_W-deep, PIX_W-wide delay line with an enable. Two instances, chained.

Test Plan:
1. Flat frame, all pixels 100, T=10: expect 4096 outputs all 0, one ready_out pulse, busy low afterwards.
2. Vertical step (cols 0..31 = 0, 32..63 = 200), T=63:
   - out_pix=255 at cols 31 and 32, rows 1..62 (mag=800);
   - all other positions 0.
3. Step height 16 (mag=64): with T=64, no edges; with T=63, edges at cols 31/32 rows 1..62.
4. Scenario 2 with out_ready random at 50%: stream identical to scenario 2. in_ready is low in every stalled cycle, and the output count is exactly 4096.
5. Reset asserted after 1000 accepted pixels:
   - next cycle in_ready=0, out_valid=0, busy=0;
   - a new start then yields a correct scenario-2 frame.
6. T changed to 0 mid-frame and start pulsed during RUN: no effect; output matches scenario 2; exactly one ready_out.
